// File: rtl/code_lock_pkg.sv
// Shared state encoding and default parameters for the serial code lock.
package code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        UNLOCKED = 3'd2,
        PROGRAM  = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    localparam int DEF_NUM_BITS       = 7;
    localparam int DEF_KEY_LEN        = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;

    localparam int DEF_IDX_W  = $clog2(DEF_KEY_LEN);
    localparam int DEF_FAIL_W = $clog2(DEF_MAX_FAILS + 1);
    localparam int DEF_TMR_W  = $clog2(DEF_LOCKOUT_CYCLES + 1);

endpackage

// File: rtl/code_lock_ctrl_byte_equal.sv
// Single shared byte comparator: XNOR each bit pair, then AND-reduce.
module byte_equal #(
    parameter int NUM_BITS = 7
) (
    input  logic [NUM_BITS:0] a,
    input  logic [NUM_BITS:0] b,
    output logic              eq
);

    assign eq = &(a ~^ b);

endmodule

// File: rtl/code_lock_ctrl.sv
// Serial code lock: checks KEY_LEN entered bytes against a stored key with one
// time-shared comparator, tracks consecutive failures and enforces a lockout.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int NUM_BITS       = DEF_NUM_BITS,
    parameter int KEY_LEN        = DEF_KEY_LEN,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [NUM_BITS:0]                  in_data,
    output logic                               in_ready,
    input  logic                               prog,
    input  logic                               lock,
    output logic                               unlocked,
    output logic                               error,
    output logic                               locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int IDX_W  = $clog2(KEY_LEN);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KEY_LEN - 1);
    localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

    state_t              state;
    logic [NUM_BITS:0]   key [KEY_LEN];
    logic [IDX_W-1:0]    idx;
    logic                mism;
    logic [TMR_W-1:0]    timer;
    logic                eq;
    logic                accept;
    logic                final_mism;
    logic [FAIL_W-1:0]   fail_next;

    byte_equal #(.NUM_BITS(NUM_BITS)) u_cmp (
        .a  (in_data),
        .b  (key[idx]),
        .eq (eq)
    );

    assign in_ready   = (state != LOCKOUT);
    assign unlocked   = (state == UNLOCKED) || (state == PROGRAM);
    assign locked_out = (state == LOCKOUT);
    assign accept     = in_valid & in_ready;
    assign final_mism = mism | ~eq;
    assign fail_next  = (fail_count == FAIL_MAX) ? fail_count : fail_count + FAIL_W'(1);

    // Every attempt consumes all KEY_LEN bytes; the verdict is taken on the last one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            mism       <= 1'b0;
            timer      <= '0;
            error      <= 1'b0;
            fail_count <= '0;
            for (int i = 0; i < KEY_LEN; i++) begin
                key[i] <= '0;
            end
        end else begin
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mism  <= ~eq;
                        idx   <= ONE_IDX;
                        state <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (!final_mism) begin
                                fail_count <= '0;
                                state      <= UNLOCKED;
                            end else begin
                                error      <= 1'b1;
                                fail_count <= fail_next;
                                if (fail_next == FAIL_MAX) begin
                                    timer <= TMR_LOAD;
                                    state <= LOCKOUT;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            mism <= final_mism;
                            idx  <= idx + ONE_IDX;
                        end
                    end
                end
                // lock wins over a simultaneous byte, which is then dropped.
                UNLOCKED: begin
                    if (lock) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else if (accept && prog) begin
                        key[0] <= in_data;
                        idx    <= ONE_IDX;
                        state  <= PROGRAM;
                    end
                end
                PROGRAM: begin
                    if (lock) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else if (accept) begin
                        key[idx] <= in_data;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= UNLOCKED;
                        end else begin
                            idx <= idx + ONE_IDX;
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer <= TMR_ONE) begin
                        timer      <= '0;
                        fail_count <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Sequential controller that time-shares one 8-bit equality comparator to check a serially entered multi-byte code against a stored key. Bytes arrive on a valid/ready stream. The block tracks position, accumulates the per-byte match result, and grants or denies unlock. It also counts failed attempts, enforces a timed lockout, and lets the key be reprogrammed while unlocked. It sits between a keypad/switch input stage and the LED/status outputs.

## Interface
- NUM_BITS, 7, MSB index of a data byte (data width NUM_BITS+1)
- KEY_LEN, 4, bytes per code (≥2)
- MAX_FAILS, 3, consecutive failed attempts before lockout (≥1)
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_data holds a byte
- in_data  in  NUM_BITS+1  entered byte
- in_ready  out  1  block can accept a byte; a byte is transferred when in_valid & in_ready
- prog  in  1  sampled with each accepted byte in UNLOCKED: 1 starts key programming
- lock  in  1  relock request, level, sampled each cycle
- unlocked  out  1  high in UNLOCKED and PROGRAM
- error  out  1  one-cycle pulse after a failed attempt
- locked_out  out  1  high in LOCKOUT
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures so far

## Operation
- States: IDLE (locked, waiting), ENTRY (mid-code), UNLOCKED, PROGRAM, LOCKOUT.
- Key: KEY_LEN registers, reset value 0.
- idx: position register, width $clog2(KEY_LEN), reset 0.
- mism: sticky mismatch flag.
- Comparator: one byte_equal instance. It compares in_data with key[idx] combinationally and is evaluated only on an accepted byte.
- IDLE: an accepted byte sets mism = !eq and idx = 1, then goes to ENTRY.
- ENTRY: each accepted byte sets mism |= !eq and increments idx.
- No early abort. All KEY_LEN bytes are always consumed, even after a mismatch.
- Last byte (idx == KEY_LEN-1) with the final match:
  - Clear fail_count and idx, then go to UNLOCKED.
- Last byte with a mismatch:
  - Pulse error and increment fail_count.
  - If the new count == MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES.
  - Otherwise go to IDLE.
  - idx is cleared in both cases.
- LOCKOUT: in_ready = 0 and the timer decrements each cycle. When the timer reaches 0, go to IDLE and clear fail_count.
- UNLOCKED:
  - An accepted byte with prog = 0 is discarded.
  - An accepted byte with prog = 1 writes key[0], sets idx = 1, and goes to PROGRAM.
- PROGRAM: each accepted byte writes key[idx] and idx increments. After the write to key[KEY_LEN-1], clear idx and return to UNLOCKED.
- lock = 1 in UNLOCKED or PROGRAM: go to IDLE next cycle and clear idx.
  - lock has priority over a simultaneous byte; that byte is accepted and discarded.
  - An aborted PROGRAM keeps the bytes already written.
- lock is ignored in IDLE, ENTRY and LOCKOUT.
- in_ready is 1 in every state except LOCKOUT.
- fail_count saturates at MAX_FAILS and never wraps.

## Timing
- Reset values:
  - State IDLE, in_ready = 1.
  - unlocked = 0, error = 0, locked_out = 0, fail_count = 0.
  - Key all 0, timer 0.
- All outputs are registered or decoded from state. No combinational path from in_* to any output except in_ready, and in_ready depends on state only.
- Latency: unlocked, error, and locked_out assert on the cycle after the final byte is accepted.
- A new attempt can begin the cycle right after a failure.
- Throughput: one byte per cycle.
- locked_out is high for exactly LOCKOUT_CYCLES cycles. in_ready returns the cycle after.
- in_valid held high without a transfer (LOCKOUT): the byte is not consumed and must be held by the source.
- reset mid-attempt or mid-program: immediate return to reset values; the key is cleared.

## Structure
- Package code_lock_pkg holds:
  - state_t enum (IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT).
  - Default parameter constants.
  - Helper width localparams.
- Sub-module byte_equal: NUM_BITS-parameterized equality (bitwise XNOR then AND-reduce), purely combinational. It is the only comparator in the design.
- Key storage, idx, fail counter, lockout timer, and FSM live in code_lock_ctrl.

## Test plan
- After reset, enter 00 00 00 00 → unlocked = 1 one cycle after the 4th byte; fail_count = 0.
- Unlocked, send prog = 1 with A5 3C 0F F0, then pulse lock. Enter A5 3C 0F F0 → unlocked = 1.
- Key A5 3C 0F F0, enter A5 00 0F F0 → all 4 bytes accepted, error pulses once, fail_count = 1, unlocked = 0.
- Three wrong codes in a row → locked_out = 1 for 16 cycles with in_ready = 0. Then IDLE with fail_count = 0; the correct code unlocks.
- Two failures then the correct code → unlocked = 1 and fail_count resets to 0. A third failure afterwards gives fail_count = 1, no lockout.
- reset asserted after the 2nd byte of PROGRAM (key A5 3C 0F F0, new 11 22 ..) → key = 00 00 00 00 and state IDLE. Code 00 00 00 00 unlocks.
